// File: rtl/aes_tx_arb.sv
// aes_tx_arb: two-channel arbiter feeding one 128-bit block into a byte serializer.
// Grants one source FIFO at a time (round-robin or fixed ch0 priority), stages
// the block, pops the source with a one-cycle pulse and waits for the serializer ack.
module aes_tx_arb (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         prio_mode,
    input  logic [127:0] ch0_data,
    input  logic [127:0] ch1_data,
    input  logic         ch0_empty,
    input  logic         ch1_empty,
    output logic         ch0_require,
    output logic         ch1_require,
    output logic [127:0] ser_data,
    output logic         ser_empty,
    input  logic         ser_require,
    output logic         last_ch,
    output logic [15:0]  blk_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t       state;
    logic [127:0] stage;
    logic         stage_valid;
    logic         rr_ptr;
    logic         req0_q;
    logic         req1_q;
    logic         grant_any;
    logic         grant_ch;

    // Pick the winning channel from the current empty flags and arbitration mode
    always_comb begin
        grant_any = ~ch0_empty | ~ch1_empty;
        if (!ch0_empty && !ch1_empty) begin
            grant_ch = prio_mode ? 1'b0 : rr_ptr;
        end else begin
            grant_ch = ch0_empty;
        end
    end

    // Arbitration FSM: grant in IDLE, pop pulse in POP, wait for serializer ack in HOLD
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            stage       <= '0;
            stage_valid <= 1'b0;
            req0_q      <= 1'b0;
            req1_q      <= 1'b0;
            rr_ptr      <= 1'b0;
            last_ch     <= 1'b0;
            blk_cnt     <= '0;
        end else if (en) begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        stage       <= grant_ch ? ch1_data : ch0_data;
                        stage_valid <= 1'b1;
                        req0_q      <= ~grant_ch;
                        req1_q      <= grant_ch;
                        last_ch     <= grant_ch;
                        rr_ptr      <= ~grant_ch;
                        state       <= POP;
                    end
                end
                POP: begin
                    req0_q <= 1'b0;
                    req1_q <= 1'b0;
                    state  <= HOLD;
                end
                HOLD: begin
                    if (ser_require) begin
                        stage_valid <= 1'b0;
                        blk_cnt     <= blk_cnt + 16'd1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The pop pulse register is held through an en=0 freeze so the pulse
    // reappears once en returns; gating with en hides it while frozen.
    assign ch0_require = req0_q & en;
    assign ch1_require = req1_q & en;
    assign ser_data    = stage;
    assign ser_empty   = ~stage_valid;

endmodule

// File: tb/tb_aes_tx_arb.sv
// tb_aes_tx_arb: directed bench with a transaction-level model of the arbiter,
// bench-owned source FIFOs and an auto-acking serializer.
module tb_aes_tx_arb;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         prio_mode;
    logic [127:0] ch0_data;
    logic [127:0] ch1_data;
    logic         ch0_empty;
    logic         ch1_empty;
    logic         ch0_require;
    logic         ch1_require;
    logic [127:0] ser_data;
    logic         ser_empty;
    logic         ser_require;
    logic         last_ch;
    logic [15:0]  blk_cnt;

    int errors = 0;
    int checks = 0;

    logic [127:0] q0[$];
    logic [127:0] q1[$];

    // model state: staged block, pop still owed, last winner, next rr winner, count
    bit           m_staged;
    bit           m_pend;
    bit           m_last;
    bit           m_rr;
    logic [127:0] m_data;
    logic [15:0]  m_cnt;

    int           grant_log[$];
    logic [127:0] data_log[$];
    int           req_seen;
    bit           auto_ack;
    int           ack_dly;
    int           low_cnt;
    logic         en_next;

    always #5 clk = ~clk;

    aes_tx_arb dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .prio_mode  (prio_mode),
        .ch0_data   (ch0_data),
        .ch1_data   (ch1_data),
        .ch0_empty  (ch0_empty),
        .ch1_empty  (ch1_empty),
        .ch0_require(ch0_require),
        .ch1_require(ch1_require),
        .ser_data   (ser_data),
        .ser_empty  (ser_empty),
        .ser_require(ser_require),
        .last_ch    (last_ch),
        .blk_cnt    (blk_cnt)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic int gl(input int i);
        return (i < grant_log.size()) ? grant_log[i] : -1;
    endfunction

    function automatic logic [127:0] dl(input int i);
        return (i < data_log.size()) ? data_log[i] : '1;
    endfunction

    task automatic drive_fifo();
        ch0_empty = (q0.size() == 0);
        ch0_data  = ch0_empty ? '0 : q0[0];
        ch1_empty = (q1.size() == 0);
        ch1_data  = ch1_empty ? '0 : q1[0];
    endtask

    task automatic m_reset();
        m_staged = 1'b0;
        m_pend   = 1'b0;
        m_last   = 1'b0;
        m_rr     = 1'b0;
        m_data   = '0;
        m_cnt    = '0;
    endtask

    // Transaction view of one clock edge: one block in flight at a time; it is
    // granted when nothing is staged, popped on the following enabled edge,
    // and retired by the first enabled ack after that.
    task automatic model_edge();
        bit w;
        if (rst) begin
            m_reset();
            return;
        end
        if (!en) return;
        if (!m_staged) begin
            if (q0.size() > 0 || q1.size() > 0) begin
                if (q0.size() > 0 && q1.size() > 0) w = prio_mode ? 1'b0 : m_rr;
                else w = (q0.size() == 0);
                m_staged = 1'b1;
                m_pend   = 1'b1;
                m_last   = w;
                m_rr     = !w;
                m_data   = w ? q1[0] : q0[0];
            end
        end else if (m_pend) begin
            m_pend = 1'b0;
            if (m_last) void'(q1.pop_front());
            else        void'(q0.pop_front());
        end else if (ser_require) begin
            m_staged = 1'b0;
            m_cnt    = m_cnt + 16'd1;
        end
    endtask

    task automatic step();
        drive_fifo();
        model_edge();
        @(posedge clk);
        #1 en = en_next;
        #1;
        chk("ser_empty",   ser_empty,   !m_staged);
        chk("ser_data",    ser_data,    m_data);
        chk("ch0_require", ch0_require, m_pend && !m_last && en);
        chk("ch1_require", ch1_require, m_pend && m_last && en);
        chk("last_ch",     last_ch,     m_last);
        chk("blk_cnt",     blk_cnt,     m_cnt);
        chk("req_exclusive", ch0_require & ch1_require, 1'b0);
        if (ch0_require | ch1_require) req_seen++;
        if (ch0_require) begin grant_log.push_back(0); data_log.push_back(ser_data); end
        if (ch1_require) begin grant_log.push_back(1); data_log.push_back(ser_data); end
        drive_fifo();
        if (ser_require) begin
            ser_require = 1'b0;
        end else if (auto_ack && !ser_empty) begin
            low_cnt++;
            if (low_cnt >= ack_dly) begin
                ser_require = 1'b1;
                low_cnt     = 0;
            end
        end else begin
            low_cnt = 0;
        end
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        ser_require = 1'b0;
        low_cnt     = 0;
        q0.delete();
        q1.delete();
        step();
        rst = 1'b0;
        grant_log.delete();
        data_log.delete();
        req_seen = 0;
    endtask

    initial begin
        rst         = 1'b1;
        en          = 1'b1;
        en_next     = 1'b1;
        prio_mode   = 1'b0;
        ser_require = 1'b0;
        auto_ack    = 1'b1;
        ack_dly     = 2;
        low_cnt     = 0;
        req_seen    = 0;
        m_reset();
        drive_fifo();
        #2;
        chk("rst_ser_empty", ser_empty, 1'b1);
        chk("rst_ser_data",  ser_data,  128'h0);
        chk("rst_blk_cnt",   blk_cnt,   16'h0);
        chk("rst_req",       {ch0_require, ch1_require}, 2'b00);
        do_reset();

        // single source, three blocks on ch0
        q0.push_back(128'hA0A0_0000_0000_0000_0000_0000_0000_000A);
        q0.push_back(128'hB0B0_0000_0000_0000_0000_0000_0000_000B);
        q0.push_back(128'hC0C0_0000_0000_0000_0000_0000_0000_000C);
        repeat (15) step();
        chk("single_npops", grant_log.size(), 3);
        for (int i = 0; i < 3; i++) chk("single_ch", gl(i), 0);
        chk("single_d0", dl(0), 128'hA0A0_0000_0000_0000_0000_0000_0000_000A);
        chk("single_d1", dl(1), 128'hB0B0_0000_0000_0000_0000_0000_0000_000B);
        chk("single_d2", dl(2), 128'hC0C0_0000_0000_0000_0000_0000_0000_000C);
        chk("single_cnt", blk_cnt, 16'd3);
        chk("single_last", last_ch, 1'b0);

        // round-robin with both sources busy
        do_reset();
        for (int i = 0; i < 4; i++) begin
            q0.push_back(128'h1000 + 128'(i));
            q1.push_back(128'h2000 + 128'(i));
        end
        repeat (40) step();
        chk("rr_npops", grant_log.size(), 8);
        chk("rr_g0", gl(0), 0);
        chk("rr_g1", gl(1), 1);
        chk("rr_g2", gl(2), 0);
        chk("rr_g3", gl(3), 1);
        chk("rr_d1", dl(1), 128'h2000);
        chk("rr_cnt", blk_cnt, 16'd8);

        // fixed priority: ch0 drains before ch1 gets a grant
        do_reset();
        prio_mode = 1'b1;
        for (int i = 0; i < 4; i++) q0.push_back(128'h3000 + 128'(i));
        for (int i = 0; i < 2; i++) q1.push_back(128'h4000 + 128'(i));
        repeat (30) step();
        chk("fp_npops", grant_log.size(), 6);
        for (int i = 0; i < 4; i++) chk("fp_ch0", gl(i), 0);
        chk("fp_g4", gl(4), 1);
        chk("fp_g5", gl(5), 1);
        prio_mode = 1'b0;

        // enable freeze during POP
        do_reset();
        q0.push_back(128'h5555);
        en_next = 1'b0;
        repeat (5) step();
        chk("frz_req_seen", req_seen, 0);
        chk("frz_cnt", blk_cnt, 16'd0);
        chk("frz_staged", ser_empty, 1'b0);
        en_next = 1'b1;
        repeat (12) step();
        chk("frz_pulses", req_seen, 1);
        chk("frz_cnt_after", blk_cnt, 16'd1);

        // reset while holding a staged block
        do_reset();
        auto_ack = 1'b0;
        q0.push_back(128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF);
        repeat (3) step();
        chk("mr_staged", ser_data, 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF);
        rst = 1'b1;
        #1;
        chk("mr_ser_empty", ser_empty, 1'b1);
        chk("mr_ser_data",  ser_data,  128'h0);
        chk("mr_blk_cnt",   blk_cnt,   16'h0);
        m_reset();
        do_reset();
        auto_ack = 1'b1;
        q0.push_back(128'h6666);
        q1.push_back(128'h7777);
        repeat (10) step();
        chk("mr_next_ch", gl(0), 0);
        chk("mr_next_d", dl(0), 128'h6666);

        // counter wrap and ack while idle
        do_reset();
        auto_ack = 1'b0;
        force dut.blk_cnt = 16'hFFFF;
        #1;
        release dut.blk_cnt;
        m_cnt = 16'hFFFF;
        ser_require = 1'b1;
        repeat (3) step();
        chk("spur_cnt", blk_cnt, 16'hFFFF);
        auto_ack = 1'b1;
        q0.push_back(128'h8888);
        repeat (10) step();
        chk("wrap_cnt", blk_cnt, 16'h0000);
        chk("wrap_empty", ser_empty, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
